// File: rtl/sort_pkg.sv
// Shared constants and types for the 5-lane sorter and its output checker.
package sort_pkg;
  localparam int NUM_LANES = 5;
  localparam int DEF_WIDTH = 16;

  localparam int ERR_ORDER = 0;
  localparam int ERR_SUM   = 1;
  localparam int ERR_XOR   = 2;
  localparam int ERR_MIN   = 3;
  localparam int ERR_MAX   = 4;
  localparam int ERR_W     = 5;

  typedef logic [NUM_LANES-1:0][DEF_WIDTH-1:0] lane_vec_t;

  typedef enum logic {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } chk_state_t;
endpackage

// File: rtl/sort_delay_line.sv
// Shift register that delays {valid, vector} by LATENCY cycles; only valid bits are reset.
module sort_delay_line
  import sort_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  input  logic [NUM_LANES-1:0][WIDTH-1:0]  in_vec,
  output logic                             out_valid,
  output logic [NUM_LANES-1:0][WIDTH-1:0]  out_vec
);
  logic [LATENCY-1:0]                           vld_q;
  logic [LATENCY:0]                             vld_next;
  logic [LATENCY-1:0][NUM_LANES-1:0][WIDTH-1:0] dat_q;
  logic [LATENCY:0][NUM_LANES-1:0][WIDTH-1:0]   dat_next;

  // Index 0 is the newest stage, index LATENCY-1 the oldest.
  assign vld_next = {vld_q, in_valid};
  assign dat_next = {dat_q, in_vec};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_next[LATENCY-1:0];
  end

  always_ff @(posedge clk) begin
    dat_q <= dat_next[LATENCY-1:0];
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_vec   = dat_q[LATENCY-1];
endmodule

// File: rtl/sort_checker.sv
// Scoreboard for the 5-lane sorter: checks each sorted output against the delayed input.
module sort_checker
  import sort_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] out1,
  input  logic [WIDTH-1:0] out2,
  input  logic [WIDTH-1:0] out3,
  input  logic [WIDTH-1:0] out4,
  input  logic [WIDTH-1:0] out5,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_code,
  output logic [CNT_W-1:0] err_cycle,
  output logic             chk_valid,
  output logic             chk_pass
);
  localparam int SW = WIDTH + 3;

  logic [NUM_LANES-1:0][WIDTH-1:0] in_vec;
  logic [NUM_LANES-1:0][WIDTH-1:0] out_vec;
  logic [NUM_LANES-1:0][WIDTH-1:0] ref_vec;
  logic                            dl_valid;
  logic                            rv;
  chk_state_t                      state_q;
  chk_state_t                      state_d;
  logic [3:0]                      warm_cnt;
  logic [SW-1:0]                   sum_out;
  logic [SW-1:0]                   sum_ref;
  logic [WIDTH-1:0]                xor_out;
  logic [WIDTH-1:0]                xor_ref;
  logic [WIDTH-1:0]                ref_min;
  logic [WIDTH-1:0]                ref_max;
  logic [ERR_W-1:0]                code;
  logic                            a_valid;
  logic [ERR_W-1:0]                a_code;
  logic [CNT_W-1:0]                cycle_cnt;

  assign in_vec  = {in5, in4, in3, in2, in1};
  assign out_vec = {out5, out4, out3, out2, out1};

  sort_delay_line #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_vec    (in_vec),
    .out_valid (dl_valid),
    .out_vec   (ref_vec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_WARM;
      warm_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_WARM) warm_cnt <= warm_cnt + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_WARM && warm_cnt == 4'(LATENCY - 1)) state_d = ST_RUN;
  end

  always_comb begin
    rv = (state_q == ST_RUN) && dl_valid;
  end

  always_comb begin
    sum_out = '0;
    sum_ref = '0;
    xor_out = '0;
    xor_ref = '0;
    ref_min = ref_vec[0];
    ref_max = ref_vec[0];
    code    = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      sum_out = sum_out + SW'(out_vec[i]);
      sum_ref = sum_ref + SW'(ref_vec[i]);
      xor_out = xor_out ^ out_vec[i];
      xor_ref = xor_ref ^ ref_vec[i];
      if (ref_vec[i] < ref_min) ref_min = ref_vec[i];
      if (ref_vec[i] > ref_max) ref_max = ref_vec[i];
    end
    for (int i = 0; i < NUM_LANES - 1; i++) begin
      if (out_vec[i] > out_vec[i+1]) code[ERR_ORDER] = 1'b1;
    end
    code[ERR_SUM] = (sum_out != sum_ref);
    code[ERR_XOR] = (xor_out != xor_ref);
    code[ERR_MIN] = (out_vec[0] != ref_min);
    code[ERR_MAX] = (out_vec[NUM_LANES-1] != ref_max);
  end

  // Register the check result so statistics update one cycle after out* is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_code  <= '0;
    end else begin
      a_valid <= rv;
      a_code  <= code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt  <= '0;
      pass_count <= '0;
      fail_count <= '0;
      err_flag   <= 1'b0;
      err_code   <= '0;
      err_cycle  <= '0;
      chk_valid  <= 1'b0;
      chk_pass   <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      chk_valid <= a_valid;
      chk_pass  <= a_valid && (a_code == '0);
      if (clr) begin
        pass_count <= '0;
        fail_count <= '0;
        err_flag   <= 1'b0;
        err_code   <= '0;
        err_cycle  <= '0;
      end else if (a_valid) begin
        if (a_code == '0) begin
          if (pass_count != '1) pass_count <= pass_count + 1'b1;
        end else begin
          if (fail_count != '1) fail_count <= fail_count + 1'b1;
          if (!err_flag) begin
            err_flag  <= 1'b1;
            err_code  <= a_code;
            err_cycle <= cycle_cnt;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sort_checker.sv
// Directed bench for sort_checker: LATENCY=1 instance (small counters) and LATENCY=3 instance.
module tb_sort_checker;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [15:0] in1, in2, in3, in4, in5;
  logic [15:0] out1, out2, out3, out4, out5;

  logic [3:0]  p1, f1, ecy1;
  logic        ef1, cv1, cp1;
  logic [4:0]  ec1;
  logic [31:0] p3, f3, ecy3;
  logic        ef3, cv3, cp3;
  logic [4:0]  ec3;

  int n_chk  = 0;
  int n_fail = 0;
  int tb_cyc = 0;

  sort_checker #(.WIDTH(16), .LATENCY(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5),
    .pass_count(p1), .fail_count(f1), .err_flag(ef1), .err_code(ec1),
    .err_cycle(ecy1), .chk_valid(cv1), .chk_pass(cp1)
  );

  sort_checker #(.WIDTH(16), .LATENCY(3), .CNT_W(32)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5),
    .pass_count(p3), .fail_count(f3), .err_flag(ef3), .err_code(ec3),
    .err_cycle(ecy3), .chk_valid(cv3), .chk_pass(cp3)
  );

  always #5 clk = ~clk;

  // Edges seen since reset release; mirrors the DUT's free-running cycle counter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc = 0;
    else        tb_cyc = tb_cyc + 1;
  end

  function automatic logic [4:0][15:0] vec5(input logic [15:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  function automatic logic [4:0][15:0] sort5(input logic [4:0][15:0] v);
    logic [4:0][15:0] s;
    logic [15:0]      t;
    s = v;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 4 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    return s;
  endfunction

  // Apply inputs for the next rising edge, return at the following falling edge.
  task automatic drive(input logic [4:0][15:0] iv, input logic v, input logic [4:0][15:0] ov);
    in1 = iv[0]; in2 = iv[1]; in3 = iv[2]; in4 = iv[3]; in5 = iv[4];
    in_valid = v;
    out1 = ov[0]; out2 = ov[1]; out3 = ov[2]; out4 = ov[3]; out5 = ov[4];
    @(negedge clk);
  endtask

  logic [4:0][15:0] zv, base_in, good_out, bad_a, bad_b, bad_c;

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      drive(zv, 1'b0, zv);
      n_chk++;
      if (cv1 !== 1'b0 || cv3 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle_chk_valid: got %b/%b required 0/0", cv1, cv3);
      end
    end
    n_chk++;
    if ({p1, f1, ef1, ec1, ecy1, cp1} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_l1: got p=%0d f=%0d ef=%b ec=%b ecy=%0d cp=%b required all 0",
               p1, f1, ef1, ec1, ecy1, cp1);
    end
    n_chk++;
    if ({p3, f3, ef3, ec3, ecy3, cp3} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_l3: got p=%0d f=%0d ef=%b ec=%b required all 0", p3, f3, ef3, ec3);
    end
  endtask

  task automatic test_pass();
    drive(base_in, 1'b1, zv);
    drive(zv, 1'b0, good_out);
    drive(zv, 1'b0, good_out);
    n_chk++;
    if (cv1 !== 1'b1 || cp1 !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_chk: got valid=%b pass=%b required 1/1", cv1, cp1);
    end
    n_chk++;
    if (p1 !== 4'd1 || f1 !== 4'd0 || ef1 !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_counts: got p=%0d f=%0d ef=%b required 1/0/0", p1, f1, ef1);
    end
  endtask

  task automatic test_first_fail();
    logic [3:0] exp_cy;
    drive(base_in, 1'b1, zv);
    drive(zv, 1'b0, bad_a);
    drive(zv, 1'b0, bad_a);
    exp_cy = 4'(tb_cyc - 1);
    n_chk++;
    if (cv1 !== 1'b1 || cp1 !== 1'b0) begin
      n_fail++;
      $display("FAIL first_fail_chk: got valid=%b pass=%b required 1/0", cv1, cp1);
    end
    n_chk++;
    if (f1 !== 4'd1 || p1 !== 4'd1 || ef1 !== 1'b1 || ec1 !== 5'b01001) begin
      n_fail++;
      $display("FAIL first_fail_capture: got f=%0d p=%0d ef=%b ec=%b required 1/1/1/01001",
               f1, p1, ef1, ec1);
    end
    n_chk++;
    if (ecy1 !== exp_cy) begin
      n_fail++;
      $display("FAIL first_fail_cycle: got %0d required %0d", ecy1, exp_cy);
    end
  endtask

  task automatic test_clr();
    clr = 1'b1;
    drive(zv, 1'b0, zv);
    clr = 1'b0;
    n_chk++;
    if ({p1, f1, ef1, ec1, ecy1} !== '0) begin
      n_fail++;
      $display("FAIL clr_zero: got p=%0d f=%0d ef=%b ec=%b ecy=%0d required all 0",
               p1, f1, ef1, ec1, ecy1);
    end
  endtask

  task automatic test_sticky();
    logic [3:0] exp_cy;
    drive(base_in, 1'b1, zv);
    drive(zv, 1'b0, bad_b);
    drive(zv, 1'b0, bad_b);
    exp_cy = 4'(tb_cyc - 1);
    n_chk++;
    if (ec1 !== 5'b10110 || f1 !== 4'd1 || ef1 !== 1'b1 || ecy1 !== exp_cy) begin
      n_fail++;
      $display("FAIL sticky_first: got ec=%b f=%0d ef=%b ecy=%0d required 10110/1/1/%0d",
               ec1, f1, ef1, ecy1, exp_cy);
    end
    drive(base_in, 1'b1, zv);
    drive(zv, 1'b0, bad_c);
    drive(zv, 1'b0, bad_c);
    n_chk++;
    if (ec1 !== 5'b10110 || f1 !== 4'd2 || ecy1 !== exp_cy || cp1 !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_second: got ec=%b f=%0d ecy=%0d cp=%b required 10110/2/%0d/0",
               ec1, f1, ecy1, cp1, exp_cy);
    end
  endtask

  // Streams nvec good vectors (optional 2-cycle gap after the 4th), returns chk_valid statistics.
  task automatic stream(input int nvec, input logic gap, output int highs, output int mid_lows);
    logic [4:0][15:0] v, prev;
    int first, last, step, k;
    int cvs[$];
    prev = zv;
    k = 0;
    step = 0;
    while (k < nvec || step < nvec + (gap ? 2 : 0) + 2) begin
      if (gap && (k == 4) && (step == 4 || step == 5)) begin
        drive(zv, 1'b0, prev);
        prev = zv;
      end else if (k < nvec) begin
        if (k == 0)
          v = vec5(16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'hFFFF);
        else
          v = vec5(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                   16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                   16'($urandom_range(0, 65535)));
        drive(v, 1'b1, prev);
        prev = sort5(v);
        k++;
      end else begin
        drive(zv, 1'b0, prev);
        prev = zv;
      end
      cvs.push_back(int'(cv1));
      step++;
    end
    highs = 0; first = -1; last = -1;
    foreach (cvs[i]) if (cvs[i] == 1) begin
      highs++;
      if (first < 0) first = i;
      last = i;
    end
    mid_lows = 0;
    if (first >= 0)
      for (int i = first; i <= last; i++) if (cvs[i] == 0) mid_lows++;
  endtask

  task automatic test_back_to_back();
    int highs, lows;
    clr = 1'b1;
    drive(zv, 1'b0, zv);
    clr = 1'b0;
    stream(10, 1'b1, highs, lows);
    n_chk++;
    if (highs != 10 || lows != 2) begin
      n_fail++;
      $display("FAIL b2b_chk_valid: got highs=%0d gap=%0d required 10/2", highs, lows);
    end
    n_chk++;
    if (p1 !== 4'd10 || f1 !== 4'd0 || ef1 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_counts: got p=%0d f=%0d ef=%b required 10/0/0", p1, f1, ef1);
    end
  endtask

  task automatic test_saturation();
    int highs, lows;
    stream(8, 1'b0, highs, lows);
    n_chk++;
    if (highs != 8 || lows != 0) begin
      n_fail++;
      $display("FAIL sat_chk_valid: got highs=%0d gap=%0d required 8/0", highs, lows);
    end
    n_chk++;
    if (p1 !== 4'hF || f1 !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_count: got p=%0d f=%0d required 15/0", p1, f1);
    end
  endtask

  task automatic test_clr_collision();
    drive(base_in, 1'b1, zv);
    drive(zv, 1'b0, bad_a);
    clr = 1'b1;
    drive(zv, 1'b0, bad_a);
    clr = 1'b0;
    n_chk++;
    if ({p1, f1, ef1, ec1} !== '0) begin
      n_fail++;
      $display("FAIL clr_collision: got p=%0d f=%0d ef=%b ec=%b required all 0", p1, f1, ef1, ec1);
    end
    drive(zv, 1'b0, zv);
    n_chk++;
    if ({p1, f1, ef1} !== '0) begin
      n_fail++;
      $display("FAIL clr_collision_after: got p=%0d f=%0d ef=%b required all 0", p1, f1, ef1);
    end
  endtask

  task automatic test_reset_midstream();
    drive(base_in, 1'b1, zv);
    drive(vec5(16'd2, 16'd4, 16'd6, 16'd8, 16'd10), 1'b1, good_out);
    rst_n = 1'b0;
    drive(zv, 1'b0, zv);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(zv, 1'b0, zv);
      n_chk++;
      if (cv3 !== 1'b0 || cv1 !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_chk_valid: cycle %0d got %b/%b required 0/0", i, cv3, cv1);
      end
    end
    n_chk++;
    if (p3 !== 32'd0 || f3 !== 32'd0 || ef3 !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_counts: got p=%0d f=%0d ef=%b required 0/0/0", p3, f3, ef3);
    end
  endtask

  initial begin
    zv       = '0;
    base_in  = vec5(16'd5, 16'd3, 16'd9, 16'd1, 16'd7);
    good_out = vec5(16'd1, 16'd3, 16'd5, 16'd7, 16'd9);
    bad_a    = vec5(16'd3, 16'd1, 16'd5, 16'd7, 16'd9);
    bad_b    = vec5(16'd1, 16'd3, 16'd5, 16'd7, 16'd8);
    bad_c    = vec5(16'd1, 16'd5, 16'd3, 16'd7, 16'd9);
    rst_n = 1'b0;
    clr = 1'b0;
    in_valid = 1'b0;
    {in1, in2, in3, in4, in5} = '0;
    {out1, out2, out3, out4, out5} = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_pass();
    test_first_fail();
    test_clr();
    test_sticky();
    test_back_to_back();
    test_saturation();
    test_clr_collision();
    test_reset_midstream();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
